pulse_peak_detector: RTL and testbench

PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

---
 rtl/pulse_peak_detector.sv | 154 +++++++++++++++
 tb/tb_pulse_peak_detector.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_peak_detector.sv
// Baseline-corrected pulse trigger with peak capture, holdoff and a valid/ready
// histogram-bin event stream. Optional pile-up rejection: PULSE_PILEUP_REJECT_EN.
module pulse_peak_detector #(
  parameter int SAMPLE_W       = 12,
  parameter int BIN_W          = 12,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int MAX_WIDTH      = 255
) (
  input  logic                clk,
  input  logic                S_AXI_ARESETN,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] baseline,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic                enable,
  output logic                bin_valid,
  output logic [BIN_W-1:0]    bin_index,
  input  logic                bin_ready,
  output logic [31:0]         event_count,
  output logic [15:0]         drop_count,
  output logic [15:0]         pileup_count,
  output logic                busy
);

  localparam int WID_W = $clog2(MAX_WIDTH + 1);
  localparam int HO_W  = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [WID_W-1:0] WID_MAX = WID_W'(MAX_WIDTH);
  localparam logic [HO_W-1:0]  HO_LOAD = HO_W'(HOLDOFF_CYCLES);

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_e;

  function automatic logic [SAMPLE_W-1:0] clamp_corr(input logic signed [SAMPLE_W:0] diff);
    return (!diff[SAMPLE_W] && (diff != '0)) ? diff[SAMPLE_W-1:0] : '0;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [WID_W-1:0] sat_width(input logic [WID_W-1:0] w);
    return (w == WID_MAX) ? w : w + WID_W'(1);
  endfunction

  logic signed [SAMPLE_W:0] diff_p0;
  logic [SAMPLE_W-1:0]      corr_p1_q;
  logic                     vld_p1_q;

  state_e              state_q;
  logic [SAMPLE_W-1:0] peak_q;
  logic [WID_W-1:0]    width_q;
  logic [HO_W-1:0]     hold_q;
  logic                bin_valid_q;
  logic [BIN_W-1:0]    bin_index_q;
  logic [31:0]         event_count_q;
  logic [15:0]         drop_count_q;

  logic above_p1;
  logic emit_ok;
  logic xfer;

  assign diff_p0  = $signed({1'b0, sample}) - $signed({1'b0, baseline});
  assign above_p1 = (corr_p1_q > threshold);
  assign emit_ok  = !bin_valid_q || bin_ready;
  assign xfer     = bin_valid_q && bin_ready;

  // ---- stage 0 -> 1: baseline subtraction clamped at zero
  always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      corr_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      corr_p1_q <= clamp_corr(diff_p0);
      vld_p1_q  <= sample_valid;
    end
  end

`ifdef PULSE_PILEUP_REJECT_EN
  localparam logic [WID_W-1:0] WID_LAST = WID_W'(MAX_WIDTH - 1);
  logic [15:0] pileup_count_q;
`endif

  // ---- stage 1 -> 2: pulse FSM, peak tracking and output register
  always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= IDLE;
      peak_q        <= '0;
      width_q       <= '0;
      hold_q        <= '0;
      bin_valid_q   <= 1'b0;
      bin_index_q   <= '0;
      event_count_q <= '0;
      drop_count_q  <= '0;
`ifdef PULSE_PILEUP_REJECT_EN
      pileup_count_q <= '0;
`endif
    end else begin
      if (xfer) begin
        bin_valid_q   <= 1'b0;
        event_count_q <= event_count_q + 32'd1;
      end
      case (state_q)
        IDLE: begin
          if (vld_p1_q && enable && above_p1) begin
            state_q <= PULSE;
            peak_q  <= corr_p1_q;
            width_q <= WID_W'(1);
          end
        end
        PULSE: begin
          if (vld_p1_q) begin
            if (above_p1) begin
              peak_q  <= (corr_p1_q > peak_q) ? corr_p1_q : peak_q;
              width_q <= sat_width(width_q);
`ifdef PULSE_PILEUP_REJECT_EN
              if (width_q >= WID_LAST) begin
                state_q        <= HOLDOFF;
                hold_q         <= HO_LOAD;
                pileup_count_q <= sat_inc16(pileup_count_q);
              end
`endif
            end else begin
              // A load here overrides the clear from a same-cycle transfer.
              if (emit_ok) begin
                bin_valid_q <= 1'b1;
                bin_index_q <= peak_q[SAMPLE_W-1 -: BIN_W];
              end else begin
                drop_count_q <= sat_inc16(drop_count_q);
              end
              state_q <= HOLDOFF;
              hold_q  <= HO_LOAD;
            end
          end
        end
        HOLDOFF: begin
          if (hold_q == '0) state_q <= IDLE;
          else              hold_q  <= hold_q - HO_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bin_valid   = bin_valid_q;
  assign bin_index   = bin_index_q;
  assign event_count = event_count_q;
  assign drop_count  = drop_count_q;
  assign busy        = (state_q != IDLE);
`ifdef PULSE_PILEUP_REJECT_EN
  assign pileup_count = pileup_count_q;
`else
  assign pileup_count = 16'd0;
`endif

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Scoreboard bench for pulse_peak_detector: a sample-level reference model pushes
// expected bins; a monitor pops and checks them when the DUT presents output.
module tb_pulse_peak_detector;
  localparam int SW = 12, BW = 12, HO = 16, MW = 255;

  logic          clk = 1'b0;
  logic          S_AXI_ARESETN;
  logic          sample_valid;
  logic [SW-1:0] sample, baseline, threshold;
  logic          enable;
  logic          bin_valid;
  logic [BW-1:0] bin_index;
  logic          bin_ready;
  logic [31:0]   event_count;
  logic [15:0]   drop_count, pileup_count;
  logic          busy;

  always #5 clk = ~clk;

  pulse_peak_detector #(.SAMPLE_W(SW), .BIN_W(BW), .HOLDOFF_CYCLES(HO), .MAX_WIDTH(MW)) dut (
    .clk(clk), .S_AXI_ARESETN(S_AXI_ARESETN), .sample_valid(sample_valid), .sample(sample),
    .baseline(baseline), .threshold(threshold), .enable(enable), .bin_valid(bin_valid),
    .bin_index(bin_index), .bin_ready(bin_ready), .event_count(event_count),
    .drop_count(drop_count), .pileup_count(pileup_count), .busy(busy));

  typedef struct {int idx; int edge_no;} exp_t;
  exp_t expq[$];
  int tests = 0, fails = 0;
  int edge_n = 0;

  // Reference model: works on whole samples; state is "idle / in pulse / dead
  // until sample index N", the output register is just a pending flag.
  int m_mode, m_peak, m_n, m_dead_until, m_idx, m_drop, m_pile;
  longint m_evt;
  bit m_pend;
  bit pv, have_prev;
  int ps;
  bit en_cur;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_peak = 0; m_n = 0; m_dead_until = 0; m_idx = 0;
    m_drop = 0; m_pile = 0; m_evt = 0; m_pend = 0; have_prev = 0;
    expq.delete();
  endtask

  // Sample c was presented last cycle; e and r are the values seen at the edge
  // where the detector decides on it.
  task automatic model_step(input bit v, input int s, input bit e, input bit r);
    int corr;
    bit emit;
    emit = 0;
    corr = (s > int'(baseline)) ? s - int'(baseline) : 0;
    if (m_mode == 2 && m_idx >= m_dead_until) m_mode = 0;
    if (v && m_mode != 2) begin
      if (m_mode == 0) begin
        if (e && corr > int'(threshold)) begin m_mode = 1; m_peak = corr; m_n = 1; end
      end else if (corr > int'(threshold)) begin
        if (corr > m_peak) m_peak = corr;
        m_n++;
`ifdef PULSE_PILEUP_REJECT_EN
        if (m_n >= MW) begin
          m_mode = 2; m_dead_until = m_idx + HO + 2;
          if (m_pile < 65535) m_pile++;
        end
`endif
      end else begin
        if (!m_pend || r) emit = 1;
        else if (m_drop < 65535) m_drop++;
        m_mode = 2; m_dead_until = m_idx + HO + 2;
      end
    end
    if (m_pend && r) begin m_pend = 0; m_evt++; end
    if (emit) begin
      exp_t x;
      x.idx = m_peak >> (SW - BW);
      x.edge_no = edge_n + 1;
      m_pend = 1;
      expq.push_back(x);
    end
    m_idx++;
  endtask

  task automatic cyc(input bit v, input int s, input bit e, input bit r);
    @(negedge clk);
    sample_valid = v; sample = SW'(s); enable = e; bin_ready = r; en_cur = e;
    if (have_prev) model_step(pv, ps, e, r);
    pv = v; ps = s; have_prev = 1;
  endtask

  task automatic apply_reset(input int hold);
    @(negedge clk);
    S_AXI_ARESETN = 1'b0; sample_valid = 1'b0; bin_ready = 1'b0;
    #1;
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_bin_index", bin_index, 0);
    chk("rst_event_count", event_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_pileup_count", pileup_count, 0);
    chk("rst_busy", busy, 0);
    repeat (hold) @(negedge clk);
    S_AXI_ARESETN = 1'b1;
    model_reset();
  endtask

  task automatic flush(input string nm);
    repeat (HO + 8) cyc(1, 0, en_cur, 1);
    @(posedge clk); #1;
    chk({nm, "_event_count"}, event_count, m_evt & 64'hFFFF_FFFF);
    chk({nm, "_drop_count"}, drop_count, m_drop);
    chk({nm, "_pileup_count"}, pileup_count, m_pile);
    chk({nm, "_bin_valid"}, bin_valid, m_pend);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_queue_drained"}, expq.size(), 0);
  endtask

  initial begin
    forever begin @(posedge clk); edge_n = edge_n + 1; end
  end

  initial begin
    bit seen, pvld, prdy;
    int pidx;
    seen = 0; pvld = 0; prdy = 0; pidx = 0;
    forever begin
      @(negedge clk); #1;
      if (S_AXI_ARESETN !== 1'b1) begin
        seen = 0; pvld = 0; prdy = 0;
        continue;
      end
      if (pvld && !prdy) begin
        chk("hold_bin_valid", bin_valid, 1);
        chk("hold_bin_index", bin_index, pidx);
      end
      if (bin_valid && !seen) begin
        chk("bin_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          chk("bin_index", bin_index, expq[0].idx);
          chk("bin_valid_edge", edge_n, expq[0].edge_no);
        end
        seen = 1;
      end
      if (bin_valid && bin_ready) begin
        if (expq.size() > 0) void'(expq.pop_front());
        seen = 0;
      end
      pvld = bin_valid; prdy = bin_ready; pidx = bin_index;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int seq027[5] = '{50, 150, 400, 300, 80};
    S_AXI_ARESETN = 1'b0; sample_valid = 1'b0; sample = '0; baseline = '0;
    threshold = '0; enable = 1'b0; bin_ready = 1'b0; en_cur = 1'b1;
    model_reset();
    apply_reset(3);

    // Single pulse, expected bin 400 two edges after the falling sample.
    baseline = 0; threshold = 100;
    foreach (seq027[i]) cyc(1, seq027[i], 1, 1);
    flush("basic");
    chk("basic_one_event", event_count, 1);

    // Clamped correction and strict threshold.
    baseline = 200; threshold = 0;
    repeat (3) cyc(1, 150, 1, 1);
    repeat (2) cyc(0, 0, 1, 1);
    chk("below_baseline_busy", busy, 0);
    baseline = 0; threshold = 100;
    repeat (3) cyc(1, 100, 1, 1);
    repeat (2) cyc(0, 0, 1, 1);
    chk("equal_threshold_busy", busy, 0);
    flush("nontrigger");

    // Backpressure: first bin held, second dropped.
    cyc(1, 300, 1, 0); cyc(1, 50, 1, 0);
    repeat (30) cyc(1, 0, 1, 0);
    cyc(1, 200, 1, 0); cyc(1, 50, 1, 0);
    repeat (10) cyc(1, 0, 1, 0);
    chk("backpressure_drop", drop_count, 1);
    chk("backpressure_held_valid", bin_valid, 1);
    chk("backpressure_held_index", bin_index, 300);
    flush("backpressure");

    // Enable dropped mid-pulse: pulse completes, next one ignored.
    cyc(1, 300, 1, 1); cyc(1, 500, 1, 1); cyc(1, 600, 0, 1); cyc(1, 400, 0, 1);
    cyc(1, 10, 0, 1);
    repeat (30) cyc(1, 0, 0, 1);
    cyc(1, 700, 0, 1); cyc(1, 10, 0, 1);
    repeat (30) cyc(1, 0, 0, 1);
    en_cur = 1'b1;
    flush("enable");
    chk("enable_events", event_count, 3);

    // Long pulse: pile-up rejection or saturated width. Enable dropped so that
    // the tail of the plateau cannot retrigger after the holdoff.
    cyc(1, 500, 1, 1); cyc(1, 500, 1, 1);
    for (int i = 0; i < 298; i++) begin
      cyc(1, 500, 0, 1);
      if (i == 100) chk("pileup_busy_mid", busy, 1);
    end
    cyc(1, 0, 0, 1);
    en_cur = 1'b1;
    flush("pileup");
`ifdef PULSE_PILEUP_REJECT_EN
    chk("pileup_rejected", pileup_count, 1);
    chk("pileup_events", event_count, 3);
`else
    chk("pileup_disabled_count", pileup_count, 0);
    chk("pileup_emitted_events", event_count, 4);
`endif

    // Reset mid-pulse discards it; next pulse peaks at 250.
    cyc(1, 300, 1, 1); cyc(1, 350, 1, 1); cyc(1, 320, 1, 1);
    apply_reset(2);
    cyc(1, 150, 1, 1); cyc(1, 250, 1, 1); cyc(1, 200, 1, 1); cyc(1, 20, 1, 1);
    flush("after_reset");
    chk("after_reset_events", event_count, 1);

    // Randomized phases with random backpressure, gaps and enable toggles.
    for (int ph = 0; ph < 4; ph++) begin
      int cycles;
      bit en;
      bit rdy_lo;
      baseline = SW'($urandom_range(0, 300));
      threshold = SW'($urandom_range(50, 800));
      en = 1'b1;
      rdy_lo = (ph == 2);
      cycles = 0;
      while (cycles < 1000) begin
        int gap, len, top;
        gap = $urandom_range(0, 25);
        for (int i = 0; i < gap; i++) begin
          int s;
          if ($urandom_range(0, 99) == 0) en = !en;
          s = ($urandom_range(0, 4) == 0) ? int'(baseline) + int'(threshold)
                                          : $urandom_range(0, int'(baseline) + int'(threshold));
          cyc($urandom_range(0, 9) < 8, s, en, $urandom_range(0, 9) < (rdy_lo ? 2 : 7));
        end
        len = ($urandom_range(0, 39) == 0) ? 260 : $urandom_range(1, 12);
        top = 4095 - int'(baseline) - int'(threshold) - 1;
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 99) == 0) en = !en;
          cyc($urandom_range(0, 19) < 17,
              int'(baseline) + int'(threshold) + 1 + $urandom_range(0, top),
              en, $urandom_range(0, 9) < (rdy_lo ? 2 : 7));
        end
        cycles += gap + len;
      end
      cyc(1, 0, en, 1);
      flush("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
